// File: rtl/seq_div_32.sv
// ============================================================================
// Module   : seq_div_32
// Brief    : 32-bit unsigned restoring divider, one quotient bit per cycle.
//            Optional macro DIV_ZERO_FAST_EN adds a 1-cycle divide-by-zero path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_div_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
`ifdef DIV_ZERO_FAST_EN
    output logic        div_zero,
`endif
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] C_LAST_STEP = 6'd31;

    state_t      r_state;
    logic [31:0] r_q;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [5:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
`ifdef DIV_ZERO_FAST_EN
    logic        r_div_zero;
`endif

    logic [31:0] w_trial;
    logic [31:0] w_b;
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [31:0] w_diff;
    logic [7:0]  w_blk_g;
    logic [7:0]  w_blk_p;
    logic [8:0]  w_blk_c;
    logic        w_c_out;
    logic        w_success;

    assign w_trial = {r_rem[30:0], r_q[31]};
    assign w_b     = ~r_div;
    assign w_g     = w_trial & w_b;
    assign w_p     = w_trial ^ w_b;

    // Eight 4-bit lookahead groups; group carries chain from c_in = 1.
    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_cla_blk
            localparam int B = 4 * k;
            assign w_c[B]     = w_blk_c[k];
            assign w_c[B + 1] = w_g[B] | (w_p[B] & w_blk_c[k]);
            assign w_c[B + 2] = w_g[B + 1]
                              | (w_p[B + 1] & w_g[B])
                              | (w_p[B + 1] & w_p[B] & w_blk_c[k]);
            assign w_c[B + 3] = w_g[B + 2]
                              | (w_p[B + 2] & w_g[B + 1])
                              | (w_p[B + 2] & w_p[B + 1] & w_g[B])
                              | (w_p[B + 2] & w_p[B + 1] & w_p[B] & w_blk_c[k]);
            assign w_blk_g[k] = w_g[B + 3]
                              | (w_p[B + 3] & w_g[B + 2])
                              | (w_p[B + 3] & w_p[B + 2] & w_g[B + 1])
                              | (w_p[B + 3] & w_p[B + 2] & w_p[B + 1] & w_g[B]);
            assign w_blk_p[k] = &w_p[B + 3:B];
        end
    endgenerate

    always_comb begin
        w_blk_c[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_blk_c[i + 1] = w_blk_g[i] | (w_blk_p[i] & w_blk_c[i]);
        end
    end

    assign w_diff    = w_p ^ w_c;
    assign w_c_out   = w_blk_c[8];
    // A set rem[31] means the true trial value exceeds any 32-bit divisor.
    assign w_success = r_rem[31] | w_c_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_q         <= 32'd0;
            r_rem       <= 32'd0;
            r_div       <= 32'd0;
            r_cnt       <= 6'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            r_div_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q        <= dividend;
                        r_div      <= divisor;
                        r_rem      <= 32'd0;
                        r_cnt      <= 6'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == 32'd0) begin
                            r_q         <= 32'hFFFF_FFFF;
                            r_rem       <= dividend;
                            r_div_zero  <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
`endif
                    end
                end
                RUN: begin
                    r_rem <= w_success ? w_diff : w_trial;
                    r_q   <= {r_q[30:0], w_success};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
`ifdef DIV_ZERO_FAST_EN
                        r_div_zero  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_q;
    assign remainder = r_rem;
`ifdef DIV_ZERO_FAST_EN
    assign div_zero  = r_div_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_div_32.sv
// ============================================================================
// Module   : tb_seq_div_32
// Brief    : Directed-vector and randomized self-checking bench for seq_div_32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_div_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIV_ZERO_FAST_EN
    logic        div_zero;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    seq_div_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
`ifdef DIV_ZERO_FAST_EN
        .div_zero  (div_zero),
`endif
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        logic        dz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_wait: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output int lat);
        wait_ready();
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_result(lat);
        q = quotient;
        r = remainder;
`ifdef DIV_ZERO_FAST_EN
        dz = div_zero;
`else
        dz = 1'b0;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] q, r, a, b, q_hold, r_hold;
        logic        dz;
        int          lat;
        int          sel;
        bit          seen;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          33, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  33, 1'b0};
`ifdef DIV_ZERO_FAST_EN
        vecs[2]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1,  1'b1};
`else
        vecs[2]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          33, 1'b0};
`endif
        vecs[3]  = '{32'd12345,      32'd1,          32'd12345,      32'd0,          33, 1'b0};
        vecs[4]  = '{32'd3,          32'd10,         32'd0,          32'd3,          33, 1'b0};
        vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,          33, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33, 1'b0};
        vecs[8]  = '{32'd1000000,    32'd999,        32'd1001,       32'd1,          33, 1'b0};
        vecs[9]  = '{32'hDEAD_BEEF,  32'd10,         32'd373592855,  32'd9,          33, 1'b0};
        vecs[10] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,          33, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient",  quotient,  0);
        check("rst_remainder", remainder, 0);
`ifdef DIV_ZERO_FAST_EN
        check("rst_div_zero",  div_zero,  0);
`endif

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, dz, lat);
            check($sformatf("vec%0d_quotient", i),  q,   vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r,   vecs[i].r);
            check($sformatf("vec%0d_latency", i),   lat, vecs[i].lat);
`ifdef DIV_ZERO_FAST_EN
            check($sformatf("vec%0d_div_zero", i),  dz,  vecs[i].dz);
            check($sformatf("vec%0d_dz_clear", i),  div_zero, 0);
`endif
        end

        // Backpressure: new operands held on in_valid through RUN and a stalled DONE.
        wait_ready();
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        dividend = 32'd50;
        divisor  = 32'd5;
        wait_result(lat);
        check("bp_latency", lat, 33);
        q_hold = quotient;
        r_hold = remainder;
        check("bp_quotient",  q_hold, 14);
        check("bp_remainder", r_hold, 2);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_hold_q",         quotient,  q_hold);
            check("bp_hold_r",         remainder, r_hold);
            check("bp_hold_in_ready",  in_ready,  0);
            check("bp_hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_post_hs_in_ready",  in_ready,  1);
        check("bp_post_hs_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("bp_accept_in_ready", in_ready, 0);
        in_valid = 1'b0;
        wait_result(lat);
        check("bp2_latency",   lat,       33);
        check("bp2_quotient",  quotient,  10);
        check("bp2_remainder", remainder, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of RUN aborts the operation.
        wait_ready();
        dividend = 32'd1000;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient",  quotient,  0);
        check("abort_remainder", remainder, 0);
        check("abort_in_ready",  in_ready,  1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 0);
        run_op(32'd9, 32'd3, q, r, dz, lat);
        check("after_abort_q",   q,   3);
        check("after_abort_r",   r,   0);
        check("after_abort_lat", lat, 33);

        for (int n = 0; n < 1000; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin b = 32'd1; a = $urandom; end
                1: begin b = $urandom | 32'h1; a = $urandom % b; end
                2: begin b = $urandom_range(1, 255); a = $urandom; end
                default: begin b = $urandom; if (b == 32'd0) b = 32'd1; a = $urandom; end
            endcase
            run_op(a, b, q, r, dz, lat);
            check("rand_identity", {32'd0, q} * {32'd0, b} + {32'd0, r}, {32'd0, a});
            check("rand_rem_lt_div", (r < b), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
